// File: rtl/button_counter_multi_if.sv
// Board-side signal bundle for button_counter_multi: raw push-buttons in,
// counter value, wrap pulse and seven-segment drive out.
interface button_counter_multi_if #(
  parameter int NUM_SEGMENTS = 4
);
  logic                          BTNU;
  logic                          BTND;
  logic                          BTNC;
  logic [4*NUM_SEGMENTS-1:0]     digits;
  logic                          wrap;
  logic [NUM_SEGMENTS-1:0]       anode;
  logic [6:0]                    cathode;

  modport master (
    output BTNU, BTND, BTNC,
    input  digits, wrap, anode, cathode
  );

  modport slave (
    input  BTNU, BTND, BTNC,
    output digits, wrap, anode, cathode
  );
endinterface

// File: rtl/button_counter_multi.sv
// Multi-digit HEX/BCD up/down counter driven by three debounced buttons with
// hold-to-auto-repeat, shown on a multiplexed seven-segment display.

// Multiplexed seven-segment driver: one digit lit at a time, active-low
// anodes and cathodes (cathode bit order g..a).
module seven_seg_controller #(
  parameter int NUM_SEGMENTS = 4,
  parameter int CLK_PER      = 10,
  parameter int REFR_RATE    = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_SEGMENTS-1:0] encoded,
  output logic [NUM_SEGMENTS-1:0]   anode,
  output logic [6:0]                cathode
);
  localparam int TICKS_RAW = 1_000_000_000 / (CLK_PER * REFR_RATE * NUM_SEGMENTS);
  localparam int TICKS     = (TICKS_RAW < 1) ? 1 : TICKS_RAW;
  localparam int TW        = $clog2(TICKS + 1);
  localparam int SW        = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

  logic [TW-1:0] refresh_q, refresh_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [3:0]    nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Refresh timer steps the digit select once per digit slot.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    sel_d     = sel_q;
    if (refresh_q == TW'(TICKS - 1)) begin
      refresh_d = '0;
      sel_d     = (sel_q == SW'(NUM_SEGMENTS - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  // Select the active digit's nibble and drive its anode low.
  always_comb begin
    nib   = 4'h0;
    anode = '1;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (sel_q == SW'(i)) begin
        nib      = encoded[4*i +: 4];
        anode[i] = 1'b0;
      end
    end
    cathode = seg_decode(nib);
  end

  // Refresh state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      sel_q     <= '0;
    end else begin
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
    end
  end
endmodule

module button_counter_multi #(
  parameter string MODE            = "HEX",
  parameter int    NUM_SEGMENTS    = 4,
  parameter int    CLK_PER         = 10,
  parameter int    REFR_RATE       = 1000,
  parameter int    DEBOUNCE_CYCLES = 256,
  parameter int    REPEAT_DELAY    = 50_000_000,
  parameter int    REPEAT_PERIOD   = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  button_counter_multi_if.slave  io
);
  localparam int             DW      = 4 * NUM_SEGMENTS;
  localparam logic [3:0]     MAXD    = (MODE == "DEC") ? 4'd9 : 4'hF;
  localparam int             DCW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam int             HW      = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [HW-1:0]  RD      = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0]  RD1     = HW'(REPEAT_DELAY + 1);
  localparam logic [HW-1:0]  RDP     = HW'(REPEAT_DELAY + REPEAT_PERIOD);
  localparam bit             REP_EN  = (REPEAT_DELAY != 0);

  // Button index: 0 = up, 1 = down, 2 = clear.
  logic [2:0]     btn_raw;
  logic           rst_meta_q, rst_meta_d, rst_sync_q, rst_sync_d;
  logic [2:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]     deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [DCW-1:0] dcnt_q [3];
  logic [DCW-1:0] dcnt_d [3];
  logic [HW-1:0]  hold_q [2];
  logic [HW-1:0]  hold_d [2];
  logic [2:0]     press;
  logic [1:0]     rep;
  logic           ev_up, ev_dn, ev_clr;
  logic [DW-1:0]  digits_q, digits_d;
  logic           wrap_q, wrap_d;
  logic [NUM_SEGMENTS-1:0] anode_w;
  logic [6:0]     cathode_w;

  assign btn_raw = {io.BTNC, io.BTND, io.BTNU};

  // Ripple increment; returns {carry_out, result}.
  function automatic logic [DW:0] incr(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= MAXD) r[4*i +: 4] = 4'h0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'h1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Ripple decrement; returns {borrow_out, result}.
  function automatic logic [DW:0] decr(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'h0) r[4*i +: 4] = MAXD;
        else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'h1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

  // Reset release is synchronised; assertion stays asynchronous.
  always_comb begin
    rst_meta_d = 1'b0;
    rst_sync_d = rst_meta_q;
  end

  // Synchroniser release registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  // Per-button synchroniser, debouncer and press edge detector.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    press     = deb_q & ~deb_dly_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_LAST) deb_d[i] = ~deb_q[i];
        else                      dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  // Hold counters for up/down; after the first repeat they cycle back so a
  // pulse fires every REPEAT_PERIOD cycles.
  always_comb begin
    rep = 2'b00;
    for (int j = 0; j < 2; j++) begin
      hold_d[j] = '0;
      if (REP_EN && deb_q[j]) begin
        rep[j]    = (hold_q[j] == RD) || (hold_q[j] == RDP);
        hold_d[j] = (hold_q[j] == RDP) ? RD1 : hold_q[j] + 1'b1;
      end
    end
  end

  // Event resolution: clear, then up/down cancel, then up, then down.
  always_comb begin
    ev_up    = press[0] | rep[0];
    ev_dn    = press[1] | rep[1];
    ev_clr   = press[2];
    digits_d = digits_q;
    wrap_d   = 1'b0;
    if (ev_clr)              digits_d = '0;
    else if (ev_up && ev_dn) digits_d = digits_q;
    else if (ev_up)          {wrap_d, digits_d} = incr(digits_q);
    else if (ev_dn)          {wrap_d, digits_d} = decr(digits_q);
  end

  // Front-end and counter state registers.
  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
      for (int j = 0; j < 2; j++) hold_q[j] <= '0;
      digits_q  <= '0;
      wrap_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
      for (int j = 0; j < 2; j++) hold_q[j] <= hold_d[j];
      digits_q  <= digits_d;
      wrap_q    <= wrap_d;
    end
  end

  seven_seg_controller #(
    .NUM_SEGMENTS (NUM_SEGMENTS),
    .CLK_PER      (CLK_PER),
    .REFR_RATE    (REFR_RATE)
  ) u_disp (
    .clk     (clk),
    .rst     (rst_sync_q),
    .encoded (digits_q),
    .anode   (anode_w),
    .cathode (cathode_w)
  );

  assign io.digits  = digits_q;
  assign io.wrap    = wrap_q;
  assign io.anode   = anode_w;
  assign io.cathode = cathode_w;
endmodule

// File: tb/tb_button_counter_multi.sv
// Directed bench: a HEX/2-digit and a DEC/3-digit counter share clock and
// reset; each scenario's expected value is worked out by hand.
module tb_button_counter_multi;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int LAT = DB + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  button_counter_multi_if #(.NUM_SEGMENTS(2)) hx ();
  button_counter_multi_if #(.NUM_SEGMENTS(3)) dc ();

  button_counter_multi #(
    .MODE("HEX"), .NUM_SEGMENTS(2), .CLK_PER(10), .REFR_RATE(1000),
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_hex (.clk(clk), .rst(rst), .io(hx.slave));

  button_counter_multi #(
    .MODE("DEC"), .NUM_SEGMENTS(3), .CLK_PER(10), .REFR_RATE(1000),
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dec (.clk(clk), .rst(rst), .io(dc.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_btn(input bit dec, input int b, input logic v);
    if (dec) begin
      case (b)
        0: dc.BTNU = v;
        1: dc.BTND = v;
        default: dc.BTNC = v;
      endcase
    end else begin
      case (b)
        0: hx.BTNU = v;
        1: hx.BTND = v;
        default: hx.BTNC = v;
      endcase
    end
  endtask

  function automatic logic [11:0] cur(input bit dec);
    return dec ? dc.digits : {4'h0, hx.digits};
  endfunction

  function automatic logic cur_wrap(input bit dec);
    return dec ? dc.wrap : hx.wrap;
  endfunction

  // Clean press: sample at the exact update edge and one cycle later.
  task automatic press(input bit dec, input int b, output logic [11:0] d,
                       output logic w0, output logic w1);
    set_btn(dec, b, 1'b1);
    repeat (LAT) @(negedge clk);
    d  = cur(dec);
    w0 = cur_wrap(dec);
    @(negedge clk);
    w1 = cur_wrap(dec);
    set_btn(dec, b, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  logic [11:0] d;
  logic        w0, w1;
  int          blen [10] = '{1, 3, 2, 1, 3, 2, 3, 1, 2, 3};

  initial begin
    hx.BTNU = 0; hx.BTND = 0; hx.BTNC = 0;
    dc.BTNU = 0; dc.BTND = 0; dc.BTNC = 0;
    repeat (3) @(negedge clk);
    chk("rst_hex_digits", {20'h0, cur(0)}, 32'h0);
    chk("rst_hex_wrap", {31'h0, hx.wrap}, 32'h0);
    chk("rst_dec_digits", {20'h0, cur(1)}, 32'h0);
    chk("rst_anode", {30'h0, hx.anode}, 32'h2);
    chk("rst_cathode", {25'h0, hx.cathode}, 32'h40);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Press latency: update exactly at edge DB+3.
    hx.BTNU = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == LAT - 1) chk("lat_before", {20'h0, cur(0)}, 32'h0);
      if (k == LAT)     chk("lat_at", {20'h0, cur(0)}, 32'h1);
    end
    hx.BTNU = 1'b0;
    repeat (12) @(negedge clk);
    chk("release_nochange", {20'h0, cur(0)}, 32'h1);

    // HEX wrap both ways.
    press(0, 1, d, w0, w1);
    chk("hex_dn_to_00", {20'h0, d}, 32'h00);
    chk("hex_dn_to_00_wrap", {31'h0, w0}, 32'h0);
    press(0, 1, d, w0, w1);
    chk("hex_dn_wrap_val", {20'h0, d}, 32'hFF);
    chk("hex_dn_wrap", {31'h0, w0}, 32'h1);
    chk("hex_dn_wrap_len", {31'h0, w1}, 32'h0);
    press(0, 0, d, w0, w1);
    chk("hex_up_wrap_val", {20'h0, d}, 32'h00);
    chk("hex_up_wrap", {31'h0, w0}, 32'h1);
    chk("hex_up_wrap_len", {31'h0, w1}, 32'h0);
    press(0, 0, d, w0, w1);
    press(0, 2, d, w0, w1);
    chk("hex_clear_val", {20'h0, d}, 32'h00);
    chk("hex_clear_nowrap", {31'h0, w0}, 32'h0);

    // DEC counting and wrap.
    for (int i = 1; i <= 10; i++) begin
      press(1, 0, d, w0, w1);
      if (i == 9) chk("dec_9", {20'h0, d}, 32'h009);
    end
    chk("dec_10", {20'h0, d}, 32'h010);
    for (int i = 1; i <= 11; i++) begin
      press(1, 1, d, w0, w1);
      if (i == 10) begin
        chk("dec_down_000", {20'h0, d}, 32'h000);
        chk("dec_down_000_wrap", {31'h0, w0}, 32'h0);
      end
    end
    chk("dec_borrow_val", {20'h0, d}, 32'h999);
    chk("dec_borrow_wrap", {31'h0, w0}, 32'h1);
    press(1, 0, d, w0, w1);
    chk("dec_carry_val", {20'h0, d}, 32'h000);
    chk("dec_carry_wrap", {31'h0, w0}, 32'h1);
    chk("dec_carry_wrap_len", {31'h0, w1}, 32'h0);
    press(1, 1, d, w0, w1);
    chk("dec_borrow2_val", {20'h0, d}, 32'h999);
    chk("dec_borrow2_wrap", {31'h0, w0}, 32'h1);

    // Bounce: short pulses never debounce, then a clean hold counts once.
    for (int i = 0; i < 10; i++) begin
      hx.BTNU = 1'b1;
      repeat (blen[i]) @(negedge clk);
      hx.BTNU = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_no_event", {20'h0, cur(0)}, 32'h00);
    press(0, 0, d, w0, w1);
    chk("bounce_then_hold", {20'h0, d}, 32'h01);
    chk("bounce_settled", {20'h0, cur(0)}, 32'h01);

    // Auto-repeat: +0, then +20, +25, ... ; release after +40 lets +45 land.
    hx.BTNU = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("rep_p0", {20'h0, cur(0)}, 32'h02);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 19) chk("rep_p19", {20'h0, cur(0)}, 32'h02);
      if (k == 20) chk("rep_p20", {20'h0, cur(0)}, 32'h03);
      if (k == 24) chk("rep_p24", {20'h0, cur(0)}, 32'h03);
      if (k == 25) chk("rep_p25", {20'h0, cur(0)}, 32'h04);
      if (k == 30) chk("rep_p30", {20'h0, cur(0)}, 32'h05);
      if (k == 40) chk("rep_p40", {20'h0, cur(0)}, 32'h07);
    end
    hx.BTNU = 1'b0;
    repeat (20) @(negedge clk);
    chk("rep_final", {20'h0, cur(0)}, 32'h08);

    // Up and down together cancel.
    hx.BTNU = 1'b1; hx.BTND = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("updn_cancel", {20'h0, cur(0)}, 32'h08);
    chk("updn_nowrap", {31'h0, hx.wrap}, 32'h0);
    @(negedge clk);
    hx.BTNU = 1'b0; hx.BTND = 1'b0;
    repeat (10) @(negedge clk);
    chk("updn_after", {20'h0, cur(0)}, 32'h08);

    // Clear beats up.
    hx.BTNC = 1'b1; hx.BTNU = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("clr_up_val", {20'h0, cur(0)}, 32'h00);
    chk("clr_up_nowrap", {31'h0, hx.wrap}, 32'h0);
    @(negedge clk);
    hx.BTNC = 1'b0; hx.BTNU = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-hold clears at once; a still-held button is a fresh press.
    hx.BTNU = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("hold_pre_rst", {20'h0, cur(0)}, 32'h01);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_digits", {20'h0, cur(0)}, 32'h00);
    chk("rst_async_wrap", {31'h0, hx.wrap}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    chk("rst_fresh_press", {20'h0, cur(0)}, 32'h01);
    hx.BTNU = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_fresh_settled", {20'h0, cur(0)}, 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
